lsq_param: RTL and testbench
============================

Name: lsq_param

Overview:
- Parametrised load/store queue sitting between the memory-issue stage and the data-cache port.
- Accepts memory ops in program order and dispatches them to memory out of order, subject to address-dependency checks.
- Tracks split request/response transactions by tag and retires strictly in program order through a valid/ready commit port.
- Successor of the fixed 4-entry buffer: generalised depth and widths, handshaked memory port, tagged responses, optional store-to-load forwarding.

Parameters:
- DEPTH, 8: queue entries; power of two, minimum 2.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.
- IDX_W, $clog2(DEPTH): entry index / tag width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- issue_valid  in  1  new op offered.
- issue_ready  out  1  queue can accept.
- issue_is_store  in  1  1 = store, 0 = load.
- issue_addr  in  ADDR_W  op address.
- issue_data  in  DATA_W  store data; ignored for loads.
- issue_tag  out  IDX_W  entry index allocated on the current handshake (= tail).
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = write.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_tag  out  IDX_W  entry index of the request.
- mem_rsp_valid  in  1  response or write acknowledge.
- mem_rsp_tag  in  IDX_W  entry the response belongs to.
- mem_rsp_rdata  in  DATA_W  load data.
- commit_valid  out  1  head entry complete.
- commit_ready  in  1  retire accepted.
- commit_is_store  out  1  head op type.
- commit_addr  out  ADDR_W  head address.
- commit_data  out  DATA_W  load result, or store data for stores.
- count  out  IDX_W+1  occupied entries.

Behaviour:
- Reset: all entries FREE; head = tail = 0; count = 0; issue_ready = 1; mem_req_valid = 0; commit_valid = 0. Other outputs are don't-care while their valid is low.
- Reset mid-operation discards all entries. A mem_rsp arriving after reset targets a FREE entry and is ignored.
- Per-entry states: FREE -> WAIT (issue handshake) -> ISSUED (mem_req handshake) -> DONE (mem_rsp with matching tag) -> FREE (commit handshake).
- issue_ready = (count < DEPTH), from registered count. When full, a same-cycle commit does not admit an issue.
- Head and tail pointers wrap modulo DEPTH.
- Eligibility of a WAIT entry for dispatch:
  - Store: no older non-DONE entry has an equal address.
  - Load: no older non-DONE store has an equal address.
- Dispatch picks the oldest eligible entry, measured from head.
- Once mem_req_valid is high, the selected entry and all request fields are held stable until mem_req_ready. A newly eligible older entry does not preempt it.
- Dispatch latency: an op accepted in cycle N can drive mem_req_valid no earlier than N+1.
- Response handling:
  - mem_rsp_valid with a tag whose entry is ISSUED sets that entry DONE. Loads capture rdata; stores ignore it.
  - A response to a non-ISSUED entry is ignored and flagged by an assertion.
  - A response is never accepted in the same cycle as its request handshake.
- commit_valid = head entry DONE. The commit handshake frees head and increments it.
- Issue, dispatch, response and commit may all occur in the same cycle on distinct entries.
- count = count + issue handshake - commit handshake.

Optional Feature:
- Macro: LSQ_STORE_FWD_EN.
- Defined:
  - A WAIT load whose youngest older equal-address entry is a non-DONE store moves directly to DONE in one cycle, with that store's data; it makes no memory request.
  - Forwarding takes priority over dispatch for that load.
- Undefined: the load waits until the store is DONE, then dispatches normally.

Decomposition:
- Package lsq_pkg: entry-state enum (FREE, WAIT, ISSUED, DONE) and the entry struct (state, is_store, addr, data).
- Sub-module lsq_age_select: a rotate-from-head, oldest-first priority picker over a DEPTH-bit request vector. Returns found flag plus index. It is reused for dispatch selection and for forwarding-source search.

Test Plan:
- Reset, then issue 8 loads to 0x100..0x138, holding mem_req_ready = 1 and returning responses in reverse tag order -> 8 requests in issue order; commit_data delivered in program order; count returns to 0; issue_ready deasserted only while count = 8.
- Store 0x200 = 0xAA, then load 0x200 and load 0x300, with response latency 3 -> load 0x300 is requested before load 0x200. Load 0x200 commits 0xAA via forwarding, or via memory once the store completes when forwarding is compiled out.
- Store 0x40, then store 0x40 -> the second store is not requested until the first store's response arrives.
- Fill to DEPTH, assert issue_valid with a commit in the same cycle -> the issue is rejected that cycle and accepted the next; tail wraps from 7 to 0 correctly.
- Hold mem_req_ready = 0 for 5 cycles while an older op becomes eligible -> request payload and tag stay unchanged until the handshake.
- Assert rst with 3 ops ISSUED, then deliver their responses -> responses ignored; count = 0; commit_valid = 0.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: the per-entry lifecycle state
// and the entry record. Address/data fields are sized to the widest
// supported configuration; narrower instances zero-extend into them.
package lsq_pkg;

    localparam int ADDR_MAX = 64;
    localparam int DATA_MAX = 64;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT   = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } ent_state_e;

    typedef struct packed {
        ent_state_e            state;
        logic                  is_store;
        logic [ADDR_MAX-1:0]   addr;
        logic [DATA_MAX-1:0]   data;
    } entry_t;

endpackage

// File: rtl/lsq_age_select.sv
// Oldest-first priority picker: scans req starting at base and wrapping
// modulo DEPTH. Ports: req (request vector), base (scan start),
// found (any bit set), idx (first set position at or after base).
module lsq_age_select
    import lsq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Walk from youngest to oldest so the last hit wins (the oldest).
    always_comb begin
        found = 1'b0;
        idx   = base;
        pos   = base;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            pos = base + IDX_W'(k);
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/lsq_param.sv
// Parametrised load/store queue: in-order accept, out-of-order dispatch
// with address-dependency checks, tagged responses, in-order commit.
// Ports: issue_* (op intake, tag = tail), mem_req_* (valid/ready
// request), mem_rsp_* (tagged response), commit_* (valid/ready retire),
// count (occupancy). Optional store-to-load forwarding: LSQ_STORE_FWD_EN.
module lsq_param
    import lsq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_is_store,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_data,
    output logic [IDX_W-1:0]  issue_tag,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [IDX_W-1:0]  mem_req_tag,
    input  logic              mem_rsp_valid,
    input  logic [IDX_W-1:0]  mem_rsp_tag,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic              commit_is_store,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [DATA_W-1:0] commit_data,
    output logic [IDX_W:0]    count
);

    entry_t              ent [DEPTH];
    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;
    logic [IDX_W:0]      cnt;
    logic                lock;
    logic [IDX_W-1:0]    lock_idx;

    logic [IDX_W-1:0]    age [DEPTH];
    logic [DEPTH-1:0]    elig;
    logic [DEPTH-1:0]    fwd;
    logic [DATA_MAX-1:0] fwd_data [DEPTH];
    logic [DEPTH-1:0]    disp_req;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;

    logic issue_fire;
    logic req_fire;
    logic rsp_hit;
    logic commit_fire;

    // Distance from head: smaller means older.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i] = IDX_W'(i) - head;
        end
    end

    // A WAIT entry is blocked by any older in-flight entry to the same
    // address when either side is a store.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = (ent[i].state == WAIT);
            for (int j = 0; j < DEPTH; j++) begin
                if (age[j] < age[i] &&
                    (ent[j].state == WAIT || ent[j].state == ISSUED) &&
                    ent[j].addr == ent[i].addr &&
                    (ent[i].is_store || ent[j].is_store)) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

`ifdef LSQ_STORE_FWD_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
        logic [DEPTH-1:0] cand;
        logic             found;
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] src;

        // Bit-reversed so the oldest-first picker, started just below
        // this entry, yields the youngest older equal-address entry.
        always_comb begin
            cand = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ent[j].state != FREE && age[j] < age[g] &&
                    ent[j].addr == ent[g].addr) begin
                    cand[DEPTH-1-j] = 1'b1;
                end
            end
        end

        lsq_age_select #(.DEPTH(DEPTH)) u_src (
            .req   (cand),
            .base  (IDX_W'(DEPTH - g)),
            .found (found),
            .idx   (pick)
        );

        assign src         = IDX_W'(DEPTH - 1) - pick;
        assign fwd[g]      = ent[g].state == WAIT && !ent[g].is_store &&
                             found && ent[src].is_store &&
                             ent[src].state != DONE;
        assign fwd_data[g] = ent[src].data;
    end
`else
    assign fwd = '0;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data[i] = '0;
        end
    end
`endif

    // Forwarded loads never go to memory.
    assign disp_req = elig & ~fwd;

    lsq_age_select #(.DEPTH(DEPTH)) u_disp (
        .req   (disp_req),
        .base  (head),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // A presented request stays locked until accepted.
    assign mem_req_valid = lock | sel_found;
    assign mem_req_tag   = lock ? lock_idx : sel_idx;
    assign mem_req_write = ent[mem_req_tag].is_store;
    assign mem_req_addr  = ent[mem_req_tag].addr[ADDR_W-1:0];
    assign mem_req_wdata = ent[mem_req_tag].data[DATA_W-1:0];

    assign issue_ready = cnt < (IDX_W+1)'(DEPTH);
    assign issue_tag   = tail;
    assign count       = cnt;

    assign commit_valid    = ent[head].state == DONE;
    assign commit_is_store = ent[head].is_store;
    assign commit_addr     = ent[head].addr[ADDR_W-1:0];
    assign commit_data     = ent[head].data[DATA_W-1:0];

    assign issue_fire  = issue_valid & issue_ready;
    assign req_fire    = mem_req_valid & mem_req_ready;
    assign rsp_hit     = mem_rsp_valid &&
                         ent[mem_rsp_tag].state == ISSUED;
    assign commit_fire = commit_valid & commit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (issue_fire) begin
                ent[tail] <= '{state:    WAIT,
                               is_store: issue_is_store,
                               addr:     ADDR_MAX'(issue_addr),
                               data:     DATA_MAX'(issue_data)};
                tail <= tail + IDX_W'(1);
            end
            if (req_fire) begin
                ent[mem_req_tag].state <= ISSUED;
            end
            lock     <= mem_req_valid & ~mem_req_ready;
            lock_idx <= mem_req_tag;
            if (rsp_hit) begin
                ent[mem_rsp_tag].state <= DONE;
                if (!ent[mem_rsp_tag].is_store) begin
                    ent[mem_rsp_tag].data <= DATA_MAX'(mem_rsp_rdata);
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (fwd[i]) begin
                    ent[i].state <= DONE;
                    ent[i].data  <= fwd_data[i];
                end
            end
            if (commit_fire) begin
                ent[head].state <= FREE;
                head <= head + IDX_W'(1);
            end
            cnt <= cnt + (IDX_W+1)'(issue_fire)
                       - (IDX_W+1)'(commit_fire);
        end
    end

    // FREE targets are legitimate stale responses after a reset flush;
    // WAIT or DONE targets indicate a broken memory side.
    always_ff @(posedge clk) begin
        if (!rst && mem_rsp_valid) begin
            assert (ent[mem_rsp_tag].state == ISSUED ||
                    ent[mem_rsp_tag].state == FREE)
            else $error("lsq_param: response to entry %0d not in flight",
                        mem_rsp_tag);
        end
    end

endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: vector tables for bulk traffic plus
// hand-written sequences for ordering, hazards, back-pressure and reset.
module tb_lsq_param;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 3;
    localparam logic [63:0] K = 64'h5A5A_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic              issue_is_store = 1'b0;
    logic [ADDR_W-1:0] issue_addr = '0;
    logic [DATA_W-1:0] issue_data = '0;
    logic [IDX_W-1:0]  issue_tag;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [IDX_W-1:0]  mem_req_tag;
    logic              mem_rsp_valid = 1'b0;
    logic [IDX_W-1:0]  mem_rsp_tag = '0;
    logic [DATA_W-1:0] mem_rsp_rdata = '0;
    logic              commit_valid;
    logic              commit_ready = 1'b0;
    logic              commit_is_store;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic [IDX_W:0]    count;

    lsq_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_is_store(issue_is_store), .issue_addr(issue_addr),
        .issue_data(issue_data), .issue_tag(issue_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_rdata(mem_rsp_rdata),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_is_store(commit_is_store), .commit_addr(commit_addr),
        .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      addr;
        logic [63:0]      data;
        logic             wr;
        logic [IDX_W-1:0] tag;
        int               cyc;
    } log_t;

    typedef struct {
        logic [IDX_W-1:0] tag;
        logic [63:0]      rdata;
        int               due;
    } rsp_t;

    typedef struct {
        logic             st;
        logic [63:0]      addr;
        logic [63:0]      rdata;
        logic [IDX_W-1:0] tag;
        logic [63:0]      cdata;
    } vec_t;

    log_t        req_log [$];
    log_t        cmt_log [$];
    rsp_t        rsp_q   [$];
    logic [63:0] mem     [bit [63:0]];
    int          rsp_cyc [DEPTH];
    int          cyc      = 0;
    bit          auto_rsp = 1'b0;
    int          lat      = 3;
    bit          mon_on   = 1'b0;
    int          n_vec    = 0;
    int          n_bad    = 0;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] rd_of(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ K;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Request/commit logger, memory write model and auto responder feed.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (mem_req_valid && mem_req_ready) begin
                req_log.push_back('{mem_req_addr, mem_req_wdata,
                                    mem_req_write, mem_req_tag, cyc});
                if (mem_req_write) mem[mem_req_addr] = mem_req_wdata;
                if (auto_rsp)
                    rsp_q.push_back('{mem_req_tag, rd_of(mem_req_addr),
                                      cyc + lat});
            end
            if (commit_valid && commit_ready)
                cmt_log.push_back('{commit_addr, commit_data,
                                    commit_is_store, '0, cyc});
            chk("issue_ready_vs_count", 64'(issue_ready),
                64'(count < (IDX_W+1)'(DEPTH)));
        end
    end

    always @(posedge clk) begin
        rsp_t r;
        #1;
        mem_rsp_valid = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = r.tag;
            mem_rsp_rdata = r.rdata;
            rsp_cyc[r.tag] = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [63:0] a,
                         input logic [63:0] d,
                         output logic [IDX_W-1:0] tag);
        issue_valid    = 1'b1;
        issue_is_store = st;
        issue_addr     = a;
        issue_data     = d;
        for (int k = 0; k < 50 && !issue_ready; k++) tick();
        chk("issue_ready", 64'(issue_ready), 64'd1);
        tag = issue_tag;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n);
        for (int k = 0; k < 200 && req_log.size() < n; k++) tick();
        chk("req_count", 64'(req_log.size()), 64'(n));
    endtask

    task automatic wait_cmts(input int n);
        for (int k = 0; k < 200 && cmt_log.size() < n; k++) tick();
        chk("commit_count", 64'(cmt_log.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             v1 [8];
        vec_t             v4 [8];
        logic [IDX_W-1:0] t, t0, t1, ts1, ts2, tl;
        int               p200, p300;

        for (int i = 0; i < 8; i++) begin
            v1[i] = '{1'b0, 64'h100 + 64'(8 * i), 64'hC0DE_0000 + 64'(i),
                      IDX_W'(i), 64'hC0DE_0000 + 64'(i)};
            v4[i] = '{1'b0, 64'h500 + 64'(8 * i), 64'h0,
                      IDX_W'(5 + i), (64'h500 + 64'(8 * i)) ^ K};
        end

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        mon_on = 1'b1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_issue_ready", 64'(issue_ready), 64'd1);
        chk("reset_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset_commit_valid", 64'(commit_valid), 64'd0);

        // Eight loads, responses in reverse tag order
        mem_req_ready = 1'b1;
        commit_ready  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(v1[i].st, v1[i].addr, 64'h0, t);
            chk("s1_issue_tag", 64'(t), 64'(v1[i].tag));
        end
        chk("s1_full_count", 64'(count), 64'd8);
        chk("s1_full_ready", 64'(issue_ready), 64'd0);
        wait_reqs(8);
        for (int i = 0; i < 8; i++) begin
            chk("s1_req_addr", req_log[i].addr, v1[i].addr);
            chk("s1_req_tag", 64'(req_log[i].tag), 64'(v1[i].tag));
        end
        for (int i = 7; i >= 0; i--)
            rsp_q.push_back('{v1[i].tag, v1[i].rdata, cyc + 1 + (7 - i)});
        commit_ready = 1'b1;
        wait_cmts(8);
        for (int i = 0; i < 8; i++) begin
            chk("s1_commit_addr", cmt_log[i].addr, v1[i].addr);
            chk("s1_commit_data", cmt_log[i].data, v1[i].cdata);
        end
        chk("s1_drained_count", 64'(count), 64'd0);

        // Store then dependent and independent loads
        req_log.delete();
        cmt_log.delete();
        auto_rsp = 1'b1;
        lat = 3;
        issue(1'b1, 64'h200, 64'hAA, t);
        issue(1'b0, 64'h200, 64'h0, t);
        issue(1'b0, 64'h300, 64'h0, t);
        wait_cmts(3);
        chk("s2_c0_store", 64'(cmt_log[0].wr), 64'd1);
        chk("s2_c0_data", cmt_log[0].data, 64'hAA);
        chk("s2_c1_addr", cmt_log[1].addr, 64'h200);
        chk("s2_c1_data", cmt_log[1].data, 64'hAA);
        chk("s2_c2_data", cmt_log[2].data, 64'h300 ^ K);
        p200 = -1;
        p300 = -1;
        for (int i = 0; i < req_log.size(); i++) begin
            if (!req_log[i].wr && req_log[i].addr == 64'h200) p200 = i;
            if (!req_log[i].wr && req_log[i].addr == 64'h300) p300 = i;
        end
`ifdef LSQ_STORE_FWD_EN
        chk("s2_req_count", 64'(req_log.size()), 64'd2);
        chk("s2_ld200_not_requested", 64'(p200), 64'(-1));
        chk("s2_ld300_requested", 64'(p300 >= 0), 64'd1);
`else
        chk("s2_req_count", 64'(req_log.size()), 64'd3);
        chk("s2_ld300_before_ld200", 64'(p300 >= 0 && p300 < p200), 64'd1);
`endif

        // Two stores to the same address
        req_log.delete();
        cmt_log.delete();
        issue(1'b1, 64'h40, 64'h1, t0);
        issue(1'b1, 64'h40, 64'h2, t1);
        wait_cmts(2);
        chk("s3_req_count", 64'(req_log.size()), 64'd2);
        chk("s3_first_tag", 64'(req_log[0].tag), 64'(t0));
        chk("s3_second_tag", 64'(req_log[1].tag), 64'(t1));
        chk("s3_second_wdata", req_log[1].data, 64'h2);
        chk("s3_second_after_rsp",
            64'(req_log[1].cyc > rsp_cyc[t0]), 64'd1);
        chk("s3_commit0", cmt_log[0].data, 64'h1);
        chk("s3_commit1", cmt_log[1].data, 64'h2);

        // Fill with wrap, then full-queue issue during a commit
        req_log.delete();
        cmt_log.delete();
        commit_ready = 1'b0;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            issue(v4[i].st, v4[i].addr, 64'h0, t);
            chk("s4_issue_tag", 64'(t), 64'(v4[i].tag));
        end
        chk("s4_full_count", 64'(count), 64'd8);
        for (int k = 0; k < 100 && !commit_valid; k++) tick();
        chk("s4_head_done", 64'(commit_valid), 64'd1);
        issue_valid    = 1'b1;
        issue_is_store = 1'b0;
        issue_addr     = 64'h600;
        issue_data     = 64'h0;
        commit_ready   = 1'b1;
        chk("s4_full_rejects", 64'(issue_ready), 64'd0);
        tick();
        commit_ready = 1'b0;
        chk("s4_count_after_commit", 64'(count), 64'd7);
        chk("s4_ready_again", 64'(issue_ready), 64'd1);
        chk("s4_tail_tag", 64'(issue_tag), 64'd5);
        tick();
        issue_valid = 1'b0;
        chk("s4_refilled_count", 64'(count), 64'd8);
        commit_ready = 1'b1;
        wait_cmts(9);
        for (int i = 0; i < 8; i++)
            chk("s4_commit_data", cmt_log[i].data, v4[i].cdata);
        chk("s4_last_addr", cmt_log[8].addr, 64'h600);
        chk("s4_drained", 64'(count), 64'd0);

        // Back-pressure while an older entry becomes eligible
        req_log.delete();
        cmt_log.delete();
        auto_rsp      = 1'b0;
        commit_ready  = 1'b0;
        mem_req_ready = 1'b1;
        issue(1'b1, 64'h800, 64'h11, ts1);
        wait_reqs(1);
        mem_req_ready = 1'b0;
        issue(1'b1, 64'h800, 64'h22, ts2);
        issue(1'b0, 64'h900, 64'h0, tl);
        chk("s5_req_valid", 64'(mem_req_valid), 64'd1);
        chk("s5_req_tag", 64'(mem_req_tag), 64'(tl));
        rsp_q.push_back('{ts1, 64'h0, cyc + 1});
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s5_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("s5_hold_tag", 64'(mem_req_tag), 64'(tl));
            chk("s5_hold_addr", mem_req_addr, 64'h900);
            chk("s5_hold_write", 64'(mem_req_write), 64'd0);
        end
        chk("s5_older_done", 64'(commit_valid), 64'd1);
        auto_rsp = 1'b1;
        mem_req_ready = 1'b1;
        wait_reqs(3);
        chk("s5_held_goes_first", 64'(req_log[1].tag), 64'(tl));
        chk("s5_then_store", 64'(req_log[2].tag), 64'(ts2));
        commit_ready = 1'b1;
        wait_cmts(3);
        chk("s5_commit0", cmt_log[0].data, 64'h11);
        chk("s5_commit1", cmt_log[1].data, 64'h22);
        chk("s5_commit2", cmt_log[2].data, 64'h900 ^ K);

        // Reset with ops in flight, then late responses
        req_log.delete();
        cmt_log.delete();
        auto_rsp     = 1'b0;
        commit_ready = 1'b0;
        issue(1'b0, 64'hA00, 64'h0, t0);
        issue(1'b0, 64'hA08, 64'h0, t1);
        issue(1'b0, 64'hA10, 64'h0, t);
        wait_reqs(3);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            rsp_q.push_back('{req_log[i].tag, 64'hBAD, cyc + 1 + i});
        commit_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("s6_no_commit", 64'(commit_valid), 64'd0);
        end
        chk("s6_count", 64'(count), 64'd0);
        chk("s6_req_valid", 64'(mem_req_valid), 64'd0);
        chk("s6_issue_ready", 64'(issue_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
